// File: rtl/cache_axi_bridge_pkg.sv
// Shared definitions for the cache-to-AXI line bridge: FSM state types and
// fixed AXI4 burst encodings for one 128-bit line moved as four 32-bit beats.
package cache_axi_bridge_pkg;

  localparam int unsigned LINE_BEATS     = 4;
  localparam logic [7:0]  AXI_LEN_LINE   = 8'(LINE_BEATS - 1);
  localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:4], 4'b0000};
  endfunction

endpackage

// File: rtl/cache_axi_bridge_wr_buf.sv
// Writeback line buffer: captures the aligned address and 128-bit line on
// acceptance, then presents one 32-bit word per W handshake with wlast on beat 3.
module axi_line_wr_buf
  import cache_axi_bridge_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [31:0]  addr,
  input  logic [127:0] line,
  input  logic         advance,
  output logic [31:0]  line_addr,
  output logic [31:0]  wdata,
  output logic         wlast
);

  logic [127:0] line_q;
  logic [1:0]   beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_addr <= '0;
      line_q    <= '0;
      beat_q    <= '0;
    end else if (load) begin
      line_addr <= line_align(addr);
      line_q    <= line;
      beat_q    <= '0;
    end else if (advance) begin
      beat_q <= beat_q + 2'd1;
    end
  end

  // The counter wraps back to 0 after the last beat, so wlast is only seen in W_DATA.
  assign wdata = line_q[{beat_q, 5'b00000} +: 32];
  assign wlast = (beat_q == 2'(LINE_BEATS - 1));

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache line refill/writeback to AXI4 4-beat INCR bursts; independent read and
// write FSMs. Define CACHE_AXI_RAW_CHECK_EN to hold reads behind same-line writebacks.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int unsigned      ID_W  = 4,
  parameter logic [ID_W-1:0]  RD_ID = '0,
  parameter logic [ID_W-1:0]  WR_ID = ID_W'(1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req,
  input  logic [31:0]     rd_addr,
  output logic            rd_rdy,
  output logic            ret_valid,
  output logic [127:0]    ret_data,
  input  logic            wr_req,
  input  logic [31:0]     wr_addr,
  input  logic [127:0]    wr_data,
  output logic            wr_rdy,
  output logic            wr_valid,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  rd_state_t rd_state;
  wr_state_t wr_state;
  logic      rd_rdy_q;
  logic [1:0] rd_beat;
  logic      raw_hit;
  logic      unused_ok;

  assign arid    = RD_ID;
  assign arlen   = AXI_LEN_LINE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign awid    = WR_ID;
  assign awlen   = AXI_LEN_LINE;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign wstrb   = 4'hF;

  assign unused_ok = ^{rid, rresp, bid, bresp, rd_addr[3:0], wr_addr[3:0]};

`ifdef CACHE_AXI_RAW_CHECK_EN
  // Block a refill of a line that is buffered or being accepted for writeback.
  assign raw_hit = (!wr_rdy && (rd_addr[31:4] == awaddr[31:4])) ||
                   (wr_req && wr_rdy && (wr_addr[31:4] == rd_addr[31:4]));
`else
  assign raw_hit = 1'b0;
`endif

  assign rd_rdy = rd_rdy_q && !raw_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      rd_rdy_q  <= 1'b1;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rd_beat   <= '0;
      ret_valid <= 1'b0;
      ret_data  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (rd_req && rd_rdy) begin
          araddr   <= line_align(rd_addr);
          arvalid  <= 1'b1;
          rd_rdy_q <= 1'b0;
          rd_state <= R_ADDR;
        end
        R_ADDR: if (arready) begin
          arvalid  <= 1'b0;
          rready   <= 1'b1;
          rd_beat  <= '0;
          rd_state <= R_DATA;
        end
        R_DATA: if (rvalid) begin
          ret_data[{rd_beat, 5'b00000} +: 32] <= rdata;
          rd_beat <= rd_beat + 2'd1;
          if (rlast) begin
            rready    <= 1'b0;
            ret_valid <= 1'b1;
            rd_state  <= R_DONE;
          end
        end
        R_DONE: begin
          ret_valid <= 1'b0;
          rd_rdy_q  <= 1'b1;
          rd_state  <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  logic buf_load;
  logic buf_wlast;

  assign buf_load = (wr_state == W_IDLE) && wr_req && wr_rdy;
  assign wlast    = buf_wlast;
  assign wr_valid = bready && bvalid;

  axi_line_wr_buf u_wr_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .addr      (wr_addr),
    .line      (wr_data),
    .advance   (wvalid && wready),
    .line_addr (awaddr),
    .wdata     (wdata),
    .wlast     (buf_wlast)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_rdy   <= 1'b1;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: if (wr_req && wr_rdy) begin
          awvalid  <= 1'b1;
          wr_rdy   <= 1'b0;
          wr_state <= W_ADDR;
        end
        W_ADDR: if (awready) begin
          awvalid  <= 1'b0;
          wvalid   <= 1'b1;
          wr_state <= W_DATA;
        end
        W_DATA: if (wready && buf_wlast) begin
          wvalid   <= 1'b0;
          bready   <= 1'b1;
          wr_state <= W_RESP;
        end
        W_RESP: if (bvalid) begin
          bready   <= 1'b0;
          wr_rdy   <= 1'b1;
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge; RAW expectations follow CACHE_AXI_RAW_CHECK_EN.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_req = 1'b0;
  logic [31:0]  rd_addr = '0;
  logic         rd_rdy, ret_valid;
  logic [127:0] ret_data;
  logic         wr_req = 1'b0;
  logic [31:0]  wr_addr = '0;
  logic [127:0] wr_data = '0;
  logic         wr_rdy, wr_valid;
  logic [3:0]   arid, rid = '0, awid, bid = '0;
  logic [31:0]  araddr, awaddr, rdata = '0, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp = '0, bresp = '0;
  logic         arvalid, arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready;
  logic         awvalid, awready = 1'b0;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready = 1'b0;
  logic         bvalid = 1'b0, bready;

  int vecs = 0;
  int errs = 0;

  cache_axi_bridge #(.ID_W(4), .RD_ID(4'd0), .WR_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_valid(wr_valid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives four R beats back to back; returns one tick after the rlast beat.
  task automatic drive_r_beats(input logic [31:0] base, input logic [1:0] resp);
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(k);
      rresp  = resp;
      rlast  = (k == 3);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic test_reset;
    logic [63:0] got, exp;
    rst = 1'b1;
    tick(); tick();
    got = {56'd0, rd_rdy, wr_rdy, arvalid, awvalid, rready, wvalid, bready, ret_valid};
    exp = {56'd0, 8'b1100_0000};
    vecs++; if (got !== exp) begin errs++; $display("FAIL reset_hs got=%h exp=%h", got, exp); end
    got = {32'd0, 31'd0, wr_valid | wlast}; exp = 64'd0;
    vecs++; if (got !== exp) begin errs++; $display("FAIL reset_wrv_wlast got=%h exp=%h", got, exp); end
    vecs++; if (ret_data !== 128'd0) begin errs++; $display("FAIL reset_ret_data got=%h exp=0", ret_data); end
    got = {araddr, awaddr}; exp = 64'd0;
    vecs++; if (got !== exp) begin errs++; $display("FAIL reset_addr got=%h exp=%h", got, exp); end
    vecs++; if (wdata !== 32'd0) begin errs++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    got = {20'd0, arid, arlen, arsize, arburst, awid, awlen, awsize, awburst, wstrb};
    exp = {20'd0, 4'd0, 8'd3, 3'b010, 2'b01, 4'd1, 8'd3, 3'b010, 2'b01, 4'hF};
    vecs++; if (got !== exp) begin errs++; $display("FAIL reset_const got=%h exp=%h", got, exp); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_zero_wait;
    rd_addr = 32'h1FC0_0014;
    rd_req  = 1'b1;
    tick();
    rd_req = 1'b0;
    vecs++; if (arvalid !== 1'b1 || rd_rdy !== 1'b0) begin errs++; $display("FAIL rd_ar_assert arvalid=%b rd_rdy=%b exp 1/0", arvalid, rd_rdy); end
    vecs++; if (araddr !== 32'h1FC0_0010) begin errs++; $display("FAIL rd_araddr got=%h exp=1fc00010", araddr); end
    vecs++; if (arlen !== 8'd3) begin errs++; $display("FAIL rd_arlen got=%0d exp=3", arlen); end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    vecs++; if (arvalid !== 1'b0 || rready !== 1'b1) begin errs++; $display("FAIL rd_r_phase arvalid=%b rready=%b exp 0/1", arvalid, rready); end
    drive_r_beats(32'hA0, 2'b00);
    vecs++; if (ret_valid !== 1'b1) begin errs++; $display("FAIL rd_ret_valid got=%b exp=1", ret_valid); end
    vecs++; if (ret_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin errs++; $display("FAIL rd_ret_data got=%h exp=000000a3000000a2000000a1000000a0", ret_data); end
    tick();
    vecs++; if (ret_valid !== 1'b0 || rd_rdy !== 1'b1) begin errs++; $display("FAIL rd_pulse_end ret_valid=%b rd_rdy=%b exp 0/1", ret_valid, rd_rdy); end
  endtask

  task automatic test_write_stall;
    logic [31:0] exp_w [4];
    int k;
    exp_w[0] = 32'h1111_1111; exp_w[1] = 32'h2222_2222;
    exp_w[2] = 32'h3333_3333; exp_w[3] = 32'h4444_4444;
    wr_addr = 32'h8000_0020;
    wr_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    wr_req  = 1'b1;
    tick();
    wr_req  = 1'b0;
    wr_data = {4{32'hDEAD_BEEF}};
    for (int c = 0; c < 3; c++) begin
      vecs++; if (awvalid !== 1'b1 || awaddr !== 32'h8000_0020) begin errs++; $display("FAIL wr_aw_hold c=%0d awvalid=%b awaddr=%h exp 1/80000020", c, awvalid, awaddr); end
      tick();
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      wready = c[0];
      vecs++; if (wvalid !== 1'b1 || wdata !== exp_w[k] || wlast !== (k == 3)) begin
        errs++; $display("FAIL wr_beat k=%0d wvalid=%b wdata=%h wlast=%b exp 1/%h/%b", k, wvalid, wdata, wlast, exp_w[k], (k == 3));
      end
      tick();
      if (wready) k++;
    end
    wready = 1'b0;
    vecs++; if (k != 4) begin errs++; $display("FAIL wr_beat_count got=%0d exp=4", k); end
    vecs++; if (bready !== 1'b1 || wvalid !== 1'b0 || wr_valid !== 1'b0) begin errs++; $display("FAIL wr_resp_wait bready=%b wvalid=%b wr_valid=%b exp 1/0/0", bready, wvalid, wr_valid); end
    tick();
    bvalid = 1'b1;
    #1;
    vecs++; if (wr_valid !== 1'b1) begin errs++; $display("FAIL wr_valid_bcycle got=%b exp=1", wr_valid); end
    tick();
    bvalid = 1'b0;
    #1;
    vecs++; if (wr_valid !== 1'b0 || wr_rdy !== 1'b1 || bready !== 1'b0) begin errs++; $display("FAIL wr_done wr_valid=%b wr_rdy=%b bready=%b exp 0/1/0", wr_valid, wr_rdy, bready); end
  endtask

  task automatic test_concurrent;
    rd_addr = 32'h0000_1004;
    wr_addr = 32'h0000_2008;
    wr_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    #1;
    vecs++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin errs++; $display("FAIL cc_rdy rd_rdy=%b wr_rdy=%b exp 1/1", rd_rdy, wr_rdy); end
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    vecs++; if (arvalid !== 1'b1 || awvalid !== 1'b1) begin errs++; $display("FAIL cc_ar_aw arvalid=%b awvalid=%b exp 1/1", arvalid, awvalid); end
    vecs++; if (araddr !== 32'h0000_1000 || awaddr !== 32'h0000_2000) begin errs++; $display("FAIL cc_addr araddr=%h awaddr=%h exp 00001000/00002000", araddr, awaddr); end
    arready = 1'b1;
    awready = 1'b1;
    tick();
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b1;
    vecs++; if (rready !== 1'b1 || wvalid !== 1'b1) begin errs++; $display("FAIL cc_data_phase rready=%b wvalid=%b exp 1/1", rready, wvalid); end
    drive_r_beats(32'hC0, 2'b00);
    wready = 1'b0;
    vecs++; if (ret_valid !== 1'b1 || bready !== 1'b1) begin errs++; $display("FAIL cc_done ret_valid=%b bready=%b exp 1/1", ret_valid, bready); end
    vecs++; if (ret_data !== 128'h000000C3_000000C2_000000C1_000000C0) begin errs++; $display("FAIL cc_ret_data got=%h exp=000000c3000000c2000000c1000000c0", ret_data); end
    bvalid = 1'b1;
    #1;
    vecs++; if (wr_valid !== 1'b1) begin errs++; $display("FAIL cc_wr_valid got=%b exp=1", wr_valid); end
    tick();
    bvalid = 1'b0;
    vecs++; if (ret_valid !== 1'b0 || rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin errs++; $display("FAIL cc_idle ret_valid=%b rd_rdy=%b wr_rdy=%b exp 0/1/1", ret_valid, rd_rdy, wr_rdy); end
  endtask

  task automatic test_raw;
    wr_addr = 32'h8000_0020;
    wr_data = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    rd_addr = 32'h8000_0028;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    #1;
`ifdef CACHE_AXI_RAW_CHECK_EN
    vecs++; if (rd_rdy !== 1'b0) begin errs++; $display("FAIL raw_same_cycle rd_rdy=%b exp=0", rd_rdy); end
`else
    vecs++; if (rd_rdy !== 1'b1) begin errs++; $display("FAIL raw_off_rdy rd_rdy=%b exp=1", rd_rdy); end
`endif
    tick();
    wr_req = 1'b0;
`ifdef CACHE_AXI_RAW_CHECK_EN
    vecs++; if (arvalid !== 1'b0 || rd_rdy !== 1'b0) begin errs++; $display("FAIL raw_blocked arvalid=%b rd_rdy=%b exp 0/0", arvalid, rd_rdy); end
`else
    rd_req = 1'b0;
    vecs++; if (arvalid !== 1'b1) begin errs++; $display("FAIL raw_off_ar arvalid=%b exp=1", arvalid); end
`endif
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef CACHE_AXI_RAW_CHECK_EN
      vecs++; if (rd_rdy !== 1'b0) begin errs++; $display("FAIL raw_hold k=%0d rd_rdy=%b exp=0", k, rd_rdy); end
`endif
      tick();
    end
    wready = 1'b0;
    bvalid = 1'b1;
    #1;
    vecs++; if (wr_valid !== 1'b1) begin errs++; $display("FAIL raw_wr_valid got=%b exp=1", wr_valid); end
`ifdef CACHE_AXI_RAW_CHECK_EN
    vecs++; if (rd_rdy !== 1'b0) begin errs++; $display("FAIL raw_bcycle rd_rdy=%b exp=0", rd_rdy); end
`endif
    tick();
    bvalid = 1'b0;
`ifdef CACHE_AXI_RAW_CHECK_EN
    vecs++; if (rd_rdy !== 1'b1) begin errs++; $display("FAIL raw_release rd_rdy=%b exp=1", rd_rdy); end
    tick();
    rd_req = 1'b0;
`endif
    vecs++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0020) begin errs++; $display("FAIL raw_ar arvalid=%b araddr=%h exp 1/80000020", arvalid, araddr); end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    drive_r_beats(32'hD0, 2'b00);
    vecs++; if (ret_valid !== 1'b1 || ret_data !== 128'h000000D3_000000D2_000000D1_000000D0) begin errs++; $display("FAIL raw_read ret_valid=%b ret_data=%h exp 1/000000d3000000d2000000d1000000d0", ret_valid, ret_data); end
    tick();
  endtask

  task automatic test_reset_mid_burst;
    rd_addr = 32'h0000_3000;
    rd_req  = 1'b1;
    tick();
    rd_req  = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1;
      rdata  = 32'hF0 + 32'(k);
      tick();
    end
    rvalid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    vecs++; if (arvalid !== 1'b0 || rready !== 1'b0 || rd_rdy !== 1'b1) begin errs++; $display("FAIL rst_mid arvalid=%b rready=%b rd_rdy=%b exp 0/0/1", arvalid, rready, rd_rdy); end
    for (int c = 0; c < 4; c++) begin
      vecs++; if (ret_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_no_ret c=%0d ret_valid=%b exp=0", c, ret_valid); end
      tick();
    end
  endtask

  task automatic test_read_error_resp;
    rd_addr = 32'h0000_4008;
    rd_req  = 1'b1;
    tick();
    rd_req  = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    drive_r_beats(32'h5A0, 2'b10);
    vecs++; if (ret_valid !== 1'b1) begin errs++; $display("FAIL err_ret_valid got=%b exp=1", ret_valid); end
    vecs++; if (ret_data !== 128'h000005A3_000005A2_000005A1_000005A0) begin errs++; $display("FAIL err_ret_data got=%h exp=000005a3000005a2000005a1000005a0", ret_data); end
    tick();
    vecs++; if (ret_valid !== 1'b0) begin errs++; $display("FAIL err_pulse_end got=%b exp=0", ret_valid); end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_stall();
    test_concurrent();
    test_raw();
    test_reset_mid_burst();
    test_read_error_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
